ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU, instantiated beside the execute stage.
- Produces a 64-bit {remainder, quotient} result. Execute forwards it as ex_hi/ex_lo with ex_whilo into the EX/MEM pipeline register.
- While busy, execute holds start_i high and requests a pipeline stall through ctrl. Execute drops start_i once ready_o is seen.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH. Iteration count is WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high (`RstEnable)
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  request; held high by execute until ready_o is seen
- annul_i  input  1  abort (flush/exception); overrides start_i
- result_o  output  2*WIDTH  {remainder, quotient}; valid while ready_o = 1
- ready_o  output  1  result valid

Behaviour:
- All state and outputs are registered. Reset: state FREE, cnt 0, working register 0, result_o 0, ready_o 0. Reset wins in any state, including mid-division.
- States: FREE, BY_ZERO, ON, END.
- FREE, start_i=1 and annul_i=0:
  - divisor == 0 -> BY_ZERO.
  - else -> ON, cnt <= 0.
  - Signed mode: latch |dividend| and |divisor| (two's complement of negative operands), plus both sign bits.
  - Working register (2*WIDTH+1 bits) <= {0, |dividend|, 1'b0}.
- FREE, otherwise: hold, ready_o=0, result_o=0.
- BY_ZERO -> END. result_o <= 0, ready_o <= 1.
- ON, annul_i=1 -> FREE. cnt <= 0, ready_o=0, result_o=0, partial result discarded.
- ON, cnt != WIDTH, one iteration per cycle:
  - diff = upper WIDTH bits of working register minus {0, |divisor|}.
  - diff negative -> shift working register left by 1, shifting in 0.
  - else -> upper <= diff[WIDTH-1:0], lower shifted left by 1, shifting in 1.
  - cnt++.
- ON, cnt == WIDTH -> END.
  - quotient = low half, negated if signed and operand signs differ.
  - remainder = high half (bits 2*WIDTH:WIDTH+1), negated if signed and dividend negative.
  - result_o <= {rem, quo}, ready_o <= 1.
- END, start_i=0 -> FREE, ready_o <= 0, result_o <= 0.
- END, start_i=1 -> hold result and ready_o.
- END, annul_i=1 -> FREE, cleared.
- Latency, counted from the edge that samples start_i (edge k):
  - nonzero divisor: ready_o high after edge k+WIDTH+1 (33 for WIDTH=32).
  - zero divisor: ready_o high after edge k+2.
- Signed -2^31 / -1: quotient wraps to 0x80000000, remainder 0; no trap.
- Operands are sampled only on the FREE->ON/BY_ZERO edge. Later changes to opdata*_i are ignored.
- Sign handling is decided at start. signed_div_i is ignored after the start edge.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in FREE with a valid start, if divisor != 0 and |dividend| < |divisor| (unsigned compare on magnitudes), go directly to END.
  - result_o <= {original dividend, 0}, ready_o <= 1.
  - ready_o high after edge k+1.
  - Annul and reset rules unchanged.
- Undefined: no bypass; every nonzero-divisor operation takes the full WIDTH iterations.

Test Plan:
- DIVU 100 / 7 (start held) -> ready_o rises 33 edges after the start edge. result_o = 0x00000002_0000000E. ready_o drops and result_o clears the cycle after start_i falls.
- DIV -7 / 2 -> result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). DIV 7 / -2 -> 0x00000001_FFFFFFFD.
- DIVU 5 / 0 -> state passes through BY_ZERO; ready_o=1 after 2 edges; result_o = 0.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000. DIVU 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- Start DIVU 1000 / 3, assert annul_i for one cycle at cnt=10 -> FREE next edge, ready_o never rises. New start of 9 / 3 completes with 0x00000000_00000003.
- Assert rst at cnt=20 -> all outputs 0, state FREE next edge. With DIV_EARLY_OUT_EN: DIVU 3 / 10 -> ready after 1 edge, result_o = 0x00000003_00000000.

Source files
------------

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU), result {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: skip the iterations when |dividend| < |divisor|.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH:0]   wreg_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               signed_q;
  logic               sign1_q;
  logic               sign2_q;

  logic [WIDTH-1:0]   mag1_d;
  logic [WIDTH-1:0]   mag2_d;
  logic [WIDTH:0]     diff_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_d;

  // Operand magnitudes, trial subtraction and sign-corrected final result.
  always_comb begin
    mag1_d = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2_d = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    diff_d = {1'b0, wreg_q[2*WIDTH-1:WIDTH]} - {1'b0, dvs_q};
    quo_d  = (signed_q && (sign1_q ^ sign2_q)) ? -wreg_q[WIDTH-1:0] : wreg_q[WIDTH-1:0];
    rem_d  = (signed_q && sign1_q) ? -wreg_q[2*WIDTH:WIDTH+1] : wreg_q[2*WIDTH:WIDTH+1];
  end

  // Divider FSM with registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      wreg_q   <= '0;
      dvs_q    <= '0;
      signed_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            signed_q <= signed_div_i;
            sign1_q  <= signed_div_i & opdata1_i[WIDTH-1];
            sign2_q  <= signed_div_i & opdata2_i[WIDTH-1];
            dvs_q    <= mag2_d;
            cnt_q    <= '0;
            if (opdata2_i == '0) begin
              state_q <= S_BY_ZERO;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (mag1_d < mag2_d) begin
              // Quotient is zero, remainder is the untouched dividend.
              state_q <= S_END;
              wreg_q  <= {1'b0, opdata1_i, {WIDTH{1'b0}}};
            end
`endif
            else begin
              state_q <= S_ON;
              wreg_q  <= {{WIDTH{1'b0}}, mag1_d, 1'b0};
            end
          end else begin
            state_q <= S_FREE;
          end
        end
        S_BY_ZERO: begin
          wreg_q  <= '0;
          state_q <= S_END;
        end
        S_ON: begin
          if (annul_i) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt_q != CNT_LAST) begin
            if (diff_d[WIDTH]) begin
              wreg_q <= {wreg_q[2*WIDTH-1:0], 1'b0};
            end else begin
              wreg_q <= {diff_d[WIDTH-1:0], wreg_q[WIDTH-1:0], 1'b1};
            end
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            state_q  <= S_END;
            cnt_q    <= '0;
            result_o <= {rem_d, quo_d};
            ready_o  <= 1'b1;
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            state_q  <= S_FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (!ready_o) begin
            // Zero-divisor and early-out paths present their result one cycle after entry.
            ready_o  <= 1'b1;
            result_o <= wreg_q[2*WIDTH-1:0];
          end else begin
            state_q <= S_END;
          end
        end
        default: begin
          state_q  <= S_FREE;
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: arithmetic reference model checked every cycle,
// plus hand-computed result and latency literals.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 33;
`endif

  ex_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  bit cmp_en = 1'b0;

  // Reference: result from plain integer division, timing from the latency rules.
  bit          m_busy  = 1'b0;
  bit          m_ready = 1'b0;
  logic [63:0] m_res   = 64'd0;
  logic [63:0] m_pend  = 64'd0;
  int          m_n     = 0;
  int          m_lat   = 0;

  function automatic logic [63:0] calc(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int lat_of(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
      m_res   <= 64'd0;
      m_n     <= 0;
    end else if (m_busy) begin
      if (annul_i) begin
        m_busy <= 1'b0;
      end else if (m_n + 1 == m_lat) begin
        m_busy  <= 1'b0;
        m_ready <= 1'b1;
        m_res   <= m_pend;
      end else begin
        m_n <= m_n + 1;
      end
    end else if (m_ready) begin
      if (annul_i || !start_i) begin
        m_ready <= 1'b0;
        m_res   <= 64'd0;
      end
    end else if (start_i && !annul_i) begin
      m_busy <= 1'b1;
      m_n    <= 0;
      m_lat  <= lat_of(signed_div_i, opdata1_i, opdata2_i);
      m_pend <= calc(signed_div_i, opdata1_i, opdata2_i);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_vec++;
      if (ready_o !== m_ready || result_o !== m_res) begin
        n_mis++;
        $display("FAIL model_cmp t=%0t: ready=%b result=%h, expected ready=%b result=%h",
                 $time, ready_o, result_o, m_ready, m_res);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input string name, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_0000; signed_div_i = ~sgn;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); lat++; #1;
      if (ready_o) break;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_res"}, result_o, exp_res);
    @(posedge clk); #1;
    chk({name, "_hold"}, result_o, exp_res);
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    chk({name, "_rdy_clr"}, 64'(ready_o), 64'd0);
    chk({name, "_res_clr"}, result_o, 64'd0);
  endtask

  initial begin
    bit seen;
    int w;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    cmp_en = 1'b1;
    @(negedge clk); rst = 1'b0;

    do_op(1'b0, 32'd100, 32'd7, "divu_100_7", 64'h00000002_0000000E, 33);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 64'hFFFFFFFF_FFFFFFFD, 33);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2", 64'h00000001_FFFFFFFD, 33);
    do_op(1'b0, 32'd5, 32'd0, "divu_5_0", 64'h0, 2);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 64'h00000000_80000000, 33);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1", 64'h00000000_FFFFFFFF, 33);
    do_op(1'b0, 32'h1234_5678, 32'h0000_1234, "divu_mix", 64'h00000DA8_00010004, 33);
    do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, "div_m100_m7", 64'hFFFFFFFE_0000000E, 33);
    do_op(1'b0, 32'd3, 32'd10, "divu_3_10", 64'h00000003_00000000, LAT_SMALL);
    do_op(1'b1, 32'hFFFF_FFFD, 32'd10, "div_m3_10", 64'hFFFFFFFD_00000000, LAT_SMALL);

    // Annul at cnt=10: no result, then a fresh operation completes.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk); annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) seen = 1'b1;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    do_op(1'b0, 32'd9, 32'd3, "divu_9_3", 64'h00000000_00000003, 33);

    // Reset at cnt=20.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Reset while a result is being held.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    w = 0;
    while (w < 100) begin
      @(posedge clk); w++; #1;
      if (ready_o) break;
    end
    chk("end_pre_rst_result", result_o, 64'h00000002_0000000E);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_end_ready", 64'(ready_o), 64'd0);
    chk("rst_end_result", result_o, 64'd0);
    @(negedge clk); rst = 1'b0; start_i = 1'b0;

    do_op(1'b0, 32'd1000, 32'd3, "divu_1000_3", 64'h00000001_0000014D, 33);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
